ucie_ctl_rx_flow_ctrl: RTL and testbench

- Receive-side flow controller between the RDI receive path and the FDI consumer.
- Buffers RDI beats in an internal FIFO and drains them to FDI under a valid/ready handshake.
- Returns one credit to the link layer per drained beat.
- Sequences the RX path through IDLE/ACTIVE/DRAIN/ERROR from i_state_request, and handles overflow by flushing and latching an error.

---
 rtl/ucie_ctl_rx_flow_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ucie_ctl_rx_flow_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_rx_flow_ctrl.sv
// ucie_ctl_rx_flow_ctrl
//
// Receive-side flow controller between the RDI receive path and the FDI
// consumer. RDI beats land in a show-ahead FIFO, drain to FDI under a
// valid/ready handshake, and each drained beat returns one credit to the
// link layer. An overflow drops the offending beat, flushes the FIFO and
// parks the block in ERROR until the request is withdrawn.
//
// Optional build macro: UCIE_CTL_RX_ALMOST_FULL_EN
//   adds parameter AF_THRESH and output o_almost_full.
//
// Ports:
//   i_clk                clock, rising edge
//   i_rst                synchronous active-high reset
//   i_state_request      1 = request ACTIVE, 0 = request IDLE
//   i_rdi_pl_valid       RDI beat valid (no backpressure toward RDI)
//   i_rdi_pl_data        RDI beat data
//   i_fdi_ready          FDI consumer accepts the head beat this cycle
//   o_fdi_data           head-of-FIFO data
//   o_fdi_data_valid     head valid
//   o_credit_return      one-cycle pulse per beat popped
//   o_state              0 IDLE, 1 ACTIVE, 2 DRAIN, 3 ERROR
//   o_overflow_detected  sticky overflow flag
//   o_almost_full        (optional) count >= AF_THRESH, registered
//   o_occupancy          FIFO count, 0..DEPTH
//
// State    | meaning
// ---------+----------------------------------------------------------
// IDLE     | RX path off, beats ignored, FIFO holds nothing visible
// ACTIVE   | beats accepted into FIFO and drained to FDI
// DRAIN    | no new beats accepted, remaining entries drained to FDI
// ERROR    | overflow seen, FIFO flushed, waits for request to drop

module ucie_ctl_rx_flow_ctrl #(
  parameter int unsigned NBYTES = 32,
  parameter int unsigned DEPTH  = 16
`ifdef UCIE_CTL_RX_ALMOST_FULL_EN
  ,
  parameter int unsigned AF_THRESH = DEPTH - 2
`endif
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_state_request,
  input  logic                      i_rdi_pl_valid,
  input  logic [NBYTES-1:0]         i_rdi_pl_data,
  input  logic                      i_fdi_ready,
  output logic [NBYTES-1:0]         o_fdi_data,
  output logic                      o_fdi_data_valid,
  output logic                      o_credit_return,
  output logic [1:0]                o_state,
  output logic                      o_overflow_detected,
`ifdef UCIE_CTL_RX_ALMOST_FULL_EN
  output logic                      o_almost_full,
`endif
  output logic [$clog2(DEPTH):0]    o_occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                credit_q, credit_d;
  logic                ovf_q, ovf_d;
  logic [NBYTES-1:0]   mem_q [DEPTH];
  logic [NBYTES-1:0]   mem_d [DEPTH];

  logic fdi_valid;
  logic pop;
  logic push;
  logic ovf_evt;
  logic in_active;

  // Handshake qualifiers. Full-with-pop still accepts the beat, so the
  // overflow event needs the absence of a pop as well as a full count.
  always_comb begin
    in_active = (state_q == ST_ACTIVE);
    fdi_valid = (count_q != '0) && ((state_q == ST_ACTIVE) || (state_q == ST_DRAIN));
    pop       = fdi_valid && i_fdi_ready;
    push      = i_rdi_pl_valid && in_active && ((count_q != FULL_CNT) || pop);
    ovf_evt   = i_rdi_pl_valid && in_active && (count_q == FULL_CNT) && !pop;
  end

  // FIFO pointers, count, storage and credit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    credit_d = pop;

    if (push) begin
      mem_d[wr_ptr_q] = i_rdi_pl_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    // Overflow flushes everything at the same edge that enters ERROR.
    // The overflow cycle never pops, so no credit leaks for flushed beats.
    if (ovf_evt) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Next-state logic and sticky overflow flag.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_state_request) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (ovf_evt)               state_d = ST_ERROR;
        else if (!i_state_request) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_state_request)       state_d = ST_ACTIVE;
        else if (count_q == '0)    state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (!i_state_request) begin
          state_d = ST_IDLE;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ovf_evt) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

`ifdef UCIE_CTL_RX_ALMOST_FULL_EN
  logic af_q, af_d;

  // Tracks the post-update count; forced low with the overflow flush.
  always_comb begin
    af_d = (count_d >= CW'(AF_THRESH));
    if (ovf_evt) af_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) af_q <= 1'b0;
    else       af_q <= af_d;
  end

  assign o_almost_full = af_q;
`else
  // Almost-full tracking not built in this configuration.
`endif

  assign o_fdi_data          = mem_q[rd_ptr_q];
  assign o_fdi_data_valid    = fdi_valid;
  assign o_credit_return     = credit_q;
  assign o_state             = state_q;
  assign o_overflow_detected = ovf_q;
  assign o_occupancy         = count_q;

endmodule

// File: tb/tb_ucie_ctl_rx_flow_ctrl.sv
// Bench for ucie_ctl_rx_flow_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.

module tb_ucie_ctl_rx_flow_ctrl;

  localparam int NB    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req;
  logic          rdi_v;
  logic [NB-1:0] rdi_d;
  logic          rdy;

  logic [NB-1:0]            fdi_data;
  logic                     fdi_valid;
  logic                     credit;
  logic [1:0]               state;
  logic                     ovf;
  logic [$clog2(DEPTH):0]   occ;

  ucie_ctl_rx_flow_ctrl #(.NBYTES(NB), .DEPTH(DEPTH)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_state_request     (req),
    .i_rdi_pl_valid      (rdi_v),
    .i_rdi_pl_data       (rdi_d),
    .i_fdi_ready         (rdy),
    .o_fdi_data          (fdi_data),
    .o_fdi_data_valid    (fdi_valid),
    .o_credit_return     (credit),
    .o_state             (state),
    .o_overflow_detected (ovf),
    .o_occupancy         (occ)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: state as 0..3, FIFO contents as a queue.
  int            m_state = 0;
  logic [NB-1:0] m_q[$];
  bit            m_credit = 1'b0;
  bit            m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    int sz;
    int nxt;
    bit vout, pop, acc, ovf_e;
    if (rst) begin
      m_q.delete();
      m_state  = 0;
      m_credit = 1'b0;
      m_ovf    = 1'b0;
      return;
    end
    sz    = m_q.size();
    vout  = (sz != 0) && (m_state == 1 || m_state == 2);
    pop   = vout && rdy;
    acc   = rdi_v && (m_state == 1) && (sz < DEPTH || pop);
    ovf_e = rdi_v && (m_state == 1) && (sz == DEPTH) && !pop;
    nxt   = m_state;
    case (m_state)
      0: if (req) nxt = 1;
      1: if (ovf_e) nxt = 3; else if (!req) nxt = 2;
      2: if (req) nxt = 1; else if (sz == 0) nxt = 0;
      3: if (!req) nxt = 0;
      default: nxt = 0;
    endcase
    m_credit = pop;
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(rdi_d);
    if (ovf_e) begin
      m_q.delete();
      m_ovf = 1'b1;
    end
    if (m_state == 3 && nxt == 0) m_ovf = 1'b0;
    m_state = nxt;
  endtask

  task automatic check_all();
    bit vexp;
    vexp = (m_q.size() != 0) && (m_state == 1 || m_state == 2);
    chk("state",     32'(state),     32'(m_state));
    chk("occupancy", 32'(occ),       32'(m_q.size()));
    chk("valid",     32'(fdi_valid), 32'(vexp));
    chk("credit",    32'(credit),    32'(m_credit));
    chk("overflow",  32'(ovf),       32'(m_ovf));
    if (vexp) chk("data", fdi_data, m_q[0]);
  endtask

  // Inputs change just after the falling edge; outputs checked at the next
  // falling edge, half a cycle after the rising edge they follow.
  task automatic step(input bit r, input bit rq, input bit v,
                      input logic [NB-1:0] d, input bit rd);
    rst   = r;
    req   = rq;
    rdi_v = v;
    rdi_d = d;
    rdy   = rd;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int p_rdy, p_req, p_v;
    int credits;
    rst = 1'b1; req = 1'b0; rdi_v = 1'b0; rdi_d = '0; rdy = 1'b0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    chk("rst_data", fdi_data, 32'h0);

    // Two-beat pass-through
    step(0, 1, 0, '0, 1);
    step(0, 1, 1, 32'hA5, 1);
    chk("first_beat", fdi_data, 32'hA5);
    step(0, 1, 1, 32'h5A, 1);
    chk("second_beat", fdi_data, 32'h5A);
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);

    // Overflow: 17 beats with FDI stalled
    credits = 0;
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 1, $urandom, 0);
      credits += int'(credit);
    end
    chk("ovf_no_credit", 32'(credits), 32'd0);
    step(0, 1, 0, '0, 1);
    step(0, 1, 1, $urandom, 1);

    // Recovery from ERROR and fresh delivery
    step(0, 0, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    step(0, 1, 1, 32'h3C, 1);
    chk("fresh_beat", fdi_data, 32'h3C);
    step(0, 1, 0, '0, 1);

    // Full with simultaneous pop
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, $urandom, 0);
    step(0, 1, 1, $urandom, 1);
    chk("full_pop_occ", 32'(occ), 32'(DEPTH));
    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 0, '0, 1);

    // Drain with valid held high
    for (int i = 0; i < 3; i++) step(0, 1, 1, $urandom, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, $urandom, 1);

    // Reset mid-operation
    step(0, 1, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, $urandom, 0);
    step(1, 1, 1, $urandom, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // Random traffic in segments with varying ready/request/valid density
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(3, 0))
        0: p_rdy = 0;
        1: p_rdy = 30;
        2: p_rdy = 70;
        default: p_rdy = 100;
      endcase
      p_req = ($urandom_range(1, 0) != 0) ? 97 : 60;
      p_v   = ($urandom_range(1, 0) != 0) ? 90 : 50;
      for (int c = 0; c < 100; c++) begin
        step(($urandom_range(399, 0) == 0),
             ($urandom_range(99, 0) < p_req),
             ($urandom_range(99, 0) < p_v),
             $urandom,
             ($urandom_range(99, 0) < p_rdy));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
